// File: rtl/writeback_sequencer_if.sv
// Execute-to-writeback bundle: op handshake in, register-file and CPSR write ports out.
interface writeback_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic                  valid;
  logic                  ready;
  logic [1:0]            op;
  logic                  write_dest;
  logic                  write_cpsr;
  logic [ADDR_W-1:0]     dest_lo;
  logic [ADDR_W-1:0]     dest_hi;
  logic [DATA_W-1:0]     result;
  logic [2*DATA_W-1:0]   m_result;
  logic [DATA_W-1:0]     cpsr;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic                  cpsr_we;
  logic [DATA_W-1:0]     cpsr_data;
  logic                  pc_write;
  logic [CNT_W-1:0]      retired;
  logic [CNT_W-1:0]      stalls;

  modport master (
    output valid, op, write_dest, write_cpsr, dest_lo, dest_hi, result, m_result, cpsr,
    input  ready, rf_we, rf_addr, rf_data, cpsr_we, cpsr_data, pc_write, retired, stalls
  );

  modport slave (
    input  valid, op, write_dest, write_cpsr, dest_lo, dest_hi, result, m_result, cpsr,
    output ready, rf_we, rf_addr, rf_data, cpsr_we, cpsr_data, pc_write, retired, stalls
  );
endinterface

// File: rtl/writeback_sequencer.sv
// Serialises execute results onto the single register write port and the CPSR port.
// state   | meaning
// IDLE    | accepting ops; issues the first (or only) write of the previous op
// HI_PEND | upstream stalled; issuing the captured high word of a long multiply
module writeback_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  writeback_sequencer_if.slave bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HI_PEND = 1'b1;

  localparam logic [1:0] OP_DATA  = 2'b00;
  localparam logic [1:0] OP_SMUL  = 2'b01;
  localparam logic [1:0] OP_LMUL  = 2'b10;

  localparam logic [ADDR_W-1:0] PC_IDX = {ADDR_W{1'b1}};

  logic [0:0]        state;
  logic              ready;
  logic              accept;
  logic [ADDR_W-1:0] hi_addr;
  logic [DATA_W-1:0] hi_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              cpsr_we;
  logic [DATA_W-1:0] cpsr_data;
  logic              pc_write;
  logic [CNT_W-1:0]  retired;
  logic [CNT_W-1:0]  stalls;

  assign ready  = (state != HI_PEND);
  assign accept = bus.valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_addr   <= '0;
      hi_data   <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      cpsr_we   <= 1'b0;
      cpsr_data <= '0;
      pc_write  <= 1'b0;
      retired   <= '0;
      stalls    <= '0;
    end else begin
      rf_we    <= 1'b0;
      cpsr_we  <= 1'b0;
      pc_write <= 1'b0;
      retired  <= retired + CNT_W'(accept);
      stalls   <= stalls + CNT_W'(bus.valid & ~ready);

      if (state == HI_PEND) begin
        rf_we    <= 1'b1;
        rf_addr  <= hi_addr;
        rf_data  <= hi_data;
        pc_write <= (hi_addr == PC_IDX);
        state    <= IDLE;
      end else if (accept) begin
        cpsr_we <= bus.write_cpsr;
        if (bus.write_cpsr) begin
          cpsr_data <= bus.cpsr;
        end
        // address/data only move when a write is actually issued
        if (bus.write_dest && bus.op != 2'b11) begin
          rf_we    <= 1'b1;
          rf_addr  <= bus.dest_lo;
          pc_write <= (bus.dest_lo == PC_IDX);
          case (bus.op)
            OP_DATA: rf_data <= bus.result;
            OP_SMUL: rf_data <= bus.m_result[DATA_W-1:0];
            default: rf_data <= bus.m_result[DATA_W-1:0];
          endcase
          if (bus.op == OP_LMUL) begin
            hi_addr <= bus.dest_hi;
            hi_data <= bus.m_result[2*DATA_W-1:DATA_W];
            state   <= HI_PEND;
          end
        end
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.rf_we     = rf_we;
  assign bus.rf_addr   = rf_addr;
  assign bus.rf_data   = rf_data;
  assign bus.cpsr_we   = cpsr_we;
  assign bus.cpsr_data = cpsr_data;
  assign bus.pc_write  = pc_write;
  assign bus.retired   = retired;
  assign bus.stalls    = stalls;
endmodule
